ysyx_22050854_booth_mul_seq: RTL and testbench
==============================================

Name: ysyx_22050854_booth_mul_seq

Overview:
Iterative radix-4 Booth multiplier for the EXU's M-extension path; consumes the radix-4 selector encoding (neg / 2neg / pos / 2pos) and retires one Booth digit per cycle into a 2*XLEN accumulator.
Handles MUL/MULH/MULHSU/MULHU and MULW through a valid/ready request and a one-cycle result pulse.
Sits between the ID/EX operand latch and the EX result mux.

Parameters:
XLEN, 64, operand width; must be even.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mul_valid  in  1  request valid
flush  in  1  kill current or pending op (branch/trap)
mulw  in  1  32-bit word op: uses operand[31:0], signed x signed
mul_signed  in  2  [1]=multiplicand signed, [0]=multiplier signed; ignored when mulw=1
multiplicand  in  XLEN  rs1
multiplier  in  XLEN  rs2
mul_ready  out  1  high only in IDLE; request accepted on edge where mul_valid & mul_ready & ~flush
out_valid  out  1  one-cycle result pulse; no back-pressure
result_hi  out  XLEN  product[2*XLEN-1:XLEN]; 0 for mulw
result_lo  out  XLEN  product[XLEN-1:0]; for mulw, sign-extended product[31:0]

Behaviour:
- Clock is clk; reset is synchronous and active-high (rst).
- Reset, on the edge: state=IDLE, out_valid=0, result_hi/lo=0, accumulator=0, counter=0. mul_ready reads 0 while rst is high and 1 in the cycle after reset.
- States:
  - IDLE -> BUSY on accept.
  - BUSY -> DONE after the last iteration.
  - DONE -> IDLE unconditionally after 1 cycle.
- Load on accept:
  - W = XLEN+2 for 64-bit ops, W = 34 for mulw.
  - Extend multiplier to W bits (sign-extend if signed, else zero-extend) and append a 0 below the LSB, giving W+1 bits.
  - Extend multiplicand to 2*XLEN bits per its signedness.
  - Clear the accumulator; counter = W/2.
- Each BUSY edge performs one iteration:
  - src = multiplier[2:0], decoded by the selector.
  - PP = +M, +2M, -M (~M+1) or -2M; PP = 0 when no select bit is active.
  - acc += PP, mod 2^(2*XLEN).
  - M <<= 2; multiplier >>= 2 (arithmetic); counter -= 1.
  - Counter reaching 0 after this iteration moves the state to DONE.
- Latency:
  - out_valid is high exactly XLEN/2+1 cycles after the accept edge (33 for XLEN=64), and 17 cycles for mulw.
  - result_hi/lo are registered with out_valid and held until the next accept.
- DONE: out_valid=1 for exactly one cycle. mul_ready=0 in DONE, so the earliest next accept is the cycle after out_valid (back-to-back throughput = latency+1).
- flush:
  - In IDLE with mul_valid: no accept.
  - In BUSY or DONE: next state IDLE, out_valid forced 0 in that cycle, results unchanged.
  - flush has priority over every other event.
- rst mid-operation: identical to power-on reset; no out_valid is produced.
- Operand inputs are ignored outside the accept edge; they need not be held.

Decomposition:
- Package ysyx_22050854_mul_pkg:
  - XLEN default.
  - State enum: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - ITER64=XLEN/2+1, ITERW=17.
  - mul_signed encodings: MUL_SS=2'b11, MUL_SU=2'b10, MUL_UU=2'b00.
- Sub-module: one instance of the existing radix-4 selector ysyx_22050854_genBooth, driven by multiplier[2:0].
- PP mux, accumulator, shifters, counter and FSM stay in this module.

Test Plan:
- mul_signed=00, 3 x 5 -> out_valid 33 cycles after accept; hi=0, lo=0xF.
- mul_signed=11, 0xFFFF_FFFF_FFFF_FFFF x 0xFFFF_FFFF_FFFF_FFFF -> hi=0, lo=1.
- mul_signed=00, same operands -> hi=0xFFFF_FFFF_FFFF_FFFE, lo=1.
- mul_signed=10, rs1=-1, rs2=0xFFFF_FFFF_FFFF_FFFF -> hi=0xFFFF_FFFF_FFFF_FFFF, lo=1.
- mulw=1, 0x7FFF_FFFF x 2 -> out_valid after 17 cycles; hi=0, lo=0xFFFF_FFFF_FFFF_FFFE.
- Control corners:
  - flush in BUSY cycle 10 -> no out_valid; mul_ready=1 next cycle.
  - rst in cycle 20 of an op -> no out_valid; outputs zero.
  - back-to-back requests -> second accepted the cycle after the first out_valid; both results correct.

Source files
------------

// File: rtl/ysyx_22050854_mul_pkg.sv
// Shared constants and types for the iterative radix-4 Booth multiplier.
// Width default, FSM encoding, iteration counts and signedness codes.
package ysyx_22050854_mul_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int ITER64 = XLEN_DEFAULT / 2 + 1;
  localparam int ITERW = 17;

  localparam logic [1:0] MUL_SS = 2'b11;
  localparam logic [1:0] MUL_SU = 2'b10;
  localparam logic [1:0] MUL_UU = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ysyx_22050854_genBooth.sv
// Radix-4 Booth digit selector.
// Maps a 3-bit multiplier window to one of +M, +2M, -M, -2M or zero.
module ysyx_22050854_genBooth (
  input  logic [2:0] i_src,
  output logic       o_neg,
  output logic       o_neg2,
  output logic       o_pos,
  output logic       o_pos2
);

  always_comb begin
    o_neg  = 1'b0;
    o_neg2 = 1'b0;
    o_pos  = 1'b0;
    o_pos2 = 1'b0;
    case (i_src)
      3'b001, 3'b010: o_pos  = 1'b1;
      3'b011:         o_pos2 = 1'b1;
      3'b100:         o_neg2 = 1'b1;
      3'b101, 3'b110: o_neg  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_22050854_booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one digit per cycle.
// Covers MUL/MULH/MULHSU/MULHU and MULW with a one-cycle result pulse.
module ysyx_22050854_booth_mul_seq
  import ysyx_22050854_mul_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mul_valid,
  input  logic            flush,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            mul_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  localparam int PW = 2 * XLEN;
  localparam int MW = XLEN + 3;
  localparam int ITERL = XLEN / 2 + 1;
  localparam int CW = $clog2(ITERL + 1);
  localparam logic [PW-1:0] PP_ONE = PW'(1);

  mul_state_e r_state;
  mul_state_e w_state_nxt;

  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_mcand;
  logic [MW-1:0]   r_mplr;
  logic [CW-1:0]   r_cnt;
  logic            r_mulw;
  logic            r_out_valid;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;

  logic            w_accept;
  logic            w_busy;
  logic            w_last;
  logic            w_neg;
  logic            w_neg2;
  logic            w_pos;
  logic            w_pos2;
  logic [PW-1:0]   w_pp;
  logic [PW-1:0]   w_acc_nxt;
  logic [MW-1:0]   w_mplr_ld;
  logic [PW-1:0]   w_mcand_ld;

  assign mul_ready = (r_state == IDLE) && !rst;
  assign w_accept  = mul_valid && mul_ready && !flush;
  assign w_busy    = (r_state == BUSY);
  assign w_last    = (r_cnt == CW'(1));

  ysyx_22050854_genBooth u_sel (
    .i_src  (r_mplr[2:0]),
    .o_neg  (w_neg),
    .o_neg2 (w_neg2),
    .o_pos  (w_pos),
    .o_pos2 (w_pos2)
  );

  // Word ops sign-extend the low half; the extra multiplier bits never get used.
  always_comb begin
    w_mplr_ld  = '0;
    w_mcand_ld = '0;
    if (mulw) begin
      w_mplr_ld  = {{(MW-33){multiplier[31]}}, multiplier[31:0], 1'b0};
      w_mcand_ld = {{(PW-32){multiplicand[31]}}, multiplicand[31:0]};
    end else begin
      w_mplr_ld  = {{2{mul_signed[0] & multiplier[XLEN-1]}},
                    multiplier, 1'b0};
      w_mcand_ld = {{XLEN{mul_signed[1] & multiplicand[XLEN-1]}},
                    multiplicand};
    end
  end

  always_comb begin
    w_pp = '0;
    unique case (1'b1)
      w_pos:   w_pp = r_mcand;
      w_pos2:  w_pp = r_mcand << 1;
      w_neg:   w_pp = ~r_mcand + PP_ONE;
      w_neg2:  w_pp = ~(r_mcand << 1) + PP_ONE;
      default: w_pp = '0;
    endcase
  end

  assign w_acc_nxt = r_acc + w_pp;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_state_nxt = BUSY;
      BUSY: begin
        if (flush)       w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplr      <= '0;
      r_cnt       <= '0;
      r_mulw      <= 1'b0;
      r_out_valid <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_busy && w_last && !flush;
      if (w_accept) begin
        r_acc   <= '0;
        r_mcand <= w_mcand_ld;
        r_mplr  <= w_mplr_ld;
        r_mulw  <= mulw;
        r_cnt   <= mulw ? CW'(ITERW) : CW'(ITERL);
      end else if (w_busy && !flush) begin
        r_acc   <= w_acc_nxt;
        r_mcand <= r_mcand << 2;
        r_mplr  <= {{2{r_mplr[MW-1]}}, r_mplr[MW-1:2]};
        r_cnt   <= r_cnt - CW'(1);
        if (w_last) begin
          if (r_mulw) begin
            r_hi <= '0;
            r_lo <= {{(XLEN-32){w_acc_nxt[31]}}, w_acc_nxt[31:0]};
          end else begin
            r_hi <= w_acc_nxt[PW-1:XLEN];
            r_lo <= w_acc_nxt[XLEN-1:0];
          end
        end
      end
    end
  end

  // A flush landing in DONE swallows the pulse in that same cycle.
  assign out_valid = r_out_valid && !flush;
  assign result_hi = r_hi;
  assign result_lo = r_lo;

endmodule

// File: tb/tb_ysyx_22050854_booth_mul_seq.sv
// Directed bench for the sequential Booth multiplier.
// Table of product vectors plus flush, reset and back-to-back sequences.
module tb_ysyx_22050854_booth_mul_seq;
  import ysyx_22050854_mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mul_valid;
  logic        flush;
  logic        mulw;
  logic [1:0]  mul_signed;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        mul_ready;
  logic        out_valid;
  logic [63:0] result_hi;
  logic [63:0] result_lo;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_22050854_booth_mul_seq #(.XLEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .mul_valid    (mul_valid),
    .flush        (flush),
    .mulw         (mulw),
    .mul_signed   (mul_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .mul_ready    (mul_ready),
    .out_valid    (out_valid),
    .result_hi    (result_hi),
    .result_lo    (result_lo)
  );

  typedef struct {
    logic        w;
    logic [1:0]  sg;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] hi;
    logic [63:0] lo;
    int          lat;
  } vec_t;

  localparam int NV = 13;
  vec_t vt[NV];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    multiplicand = {$urandom, $urandom};
    multiplier   = {$urandom, $urandom};
    mulw         = 1'($urandom);
    mul_signed   = 2'($urandom);
  endtask

  task automatic accept(input logic w, input logic [1:0] sg,
                        input logic [63:0] a, input logic [63:0] b);
    int k;
    k = 0;
    while (!mul_ready && k < 100) begin
      tick();
      k++;
    end
    chk("ready_wait", 64'(mul_ready), 64'd1);
    mulw = w;
    mul_signed = sg;
    multiplicand = a;
    multiplier = b;
    mul_valid = 1'b1;
    tick();
    mul_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (out_valid) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic no_pulse(input string nm, input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (out_valid) seen++;
    end
    chk(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    int c;
    logic [63:0] hold_hi;
    logic [63:0] hold_lo;

    vt[0]  = '{1'b0, MUL_UU, 64'd3, 64'd5, 64'd0, 64'hF, 33};
    vt[1]  = '{1'b0, MUL_SS, '1, '1, 64'd0, 64'd1, 33};
    vt[2]  = '{1'b0, MUL_UU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 33};
    vt[3]  = '{1'b0, MUL_SU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 33};
    vt[4]  = '{1'b1, MUL_UU, 64'h7FFF_FFFF, 64'd2, 64'd0,
               64'hFFFF_FFFF_FFFF_FFFE, 17};
    vt[5]  = '{1'b0, MUL_SS, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA, 33};
    vt[6]  = '{1'b0, MUL_UU, 64'h8000_0000_0000_0000, 64'd2,
               64'd1, 64'd0, 33};
    vt[7]  = '{1'b0, MUL_SS, 64'h8000_0000_0000_0000,
               64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0, 33};
    vt[8]  = '{1'b0, MUL_SU, 64'd2, 64'h8000_0000_0000_0000,
               64'd1, 64'd0, 33};
    vt[9]  = '{1'b0, MUL_SU, '1, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vt[10] = '{1'b1, MUL_UU, 64'hDEAD_BEEF_0000_0003,
               64'h1234_5678_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 17};
    vt[11] = '{1'b1, MUL_SS, 64'h0001_0000, 64'h0001_0000,
               64'd0, 64'd0, 17};
    vt[12] = '{1'b0, MUL_UU, 64'h1_0000_0001, 64'h1_0000_0001,
               64'd1, 64'h0000_0002_0000_0001, 33};

    rst = 1'b1;
    mul_valid = 1'b0;
    flush = 1'b0;
    mulw = 1'b0;
    mul_signed = MUL_UU;
    multiplicand = '0;
    multiplier = '0;
    tick();
    tick();
    chk("rst_ready", 64'(mul_ready), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_hi", result_hi, 64'd0);
    chk("rst_lo", result_lo, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(mul_ready), 64'd1);

    for (int i = 0; i < NV; i++) begin
      accept(vt[i].w, vt[i].sg, vt[i].a, vt[i].b);
      chk($sformatf("v%0d_busy_ready", i), 64'(mul_ready), 64'd0);
      wait_done(c);
      chk($sformatf("v%0d_lat", i), 64'(c), 64'(vt[i].lat));
      chk($sformatf("v%0d_hi", i), result_hi, vt[i].hi);
      chk($sformatf("v%0d_lo", i), result_lo, vt[i].lo);
      chk($sformatf("v%0d_done_ready", i), 64'(mul_ready), 64'd0);
      tick();
      chk($sformatf("v%0d_pulse", i), 64'(out_valid), 64'd0);
      chk($sformatf("v%0d_idle_ready", i), 64'(mul_ready), 64'd1);
      chk($sformatf("v%0d_hold_lo", i), result_lo, vt[i].lo);
    end

    hold_hi = result_hi;
    hold_lo = result_lo;
    accept(1'b0, MUL_UU, 64'd9, 64'd9);
    for (int k = 0; k < 9; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy_ready", 64'(mul_ready), 64'd1);
    chk("flush_busy_hi", result_hi, hold_hi);
    chk("flush_busy_lo", result_lo, hold_lo);
    no_pulse("flush_busy_nopulse", 40);

    accept(1'b0, MUL_UU, 64'd6, 64'd7);
    for (int k = 0; k < 33; k++) tick();
    chk("flush_done_pre", 64'(out_valid), 64'd1);
    chk("flush_done_lo", result_lo, 64'd42);
    flush = 1'b1;
    #1;
    chk("flush_done_mask", 64'(out_valid), 64'd0);
    tick();
    flush = 1'b0;
    chk("flush_done_ready", 64'(mul_ready), 64'd1);
    chk("flush_done_valid", 64'(out_valid), 64'd0);

    mulw = 1'b0;
    mul_signed = MUL_UU;
    multiplicand = 64'd4;
    multiplier = 64'd4;
    mul_valid = 1'b1;
    flush = 1'b1;
    tick();
    mul_valid = 1'b0;
    flush = 1'b0;
    chk("flush_idle_ready", 64'(mul_ready), 64'd1);
    no_pulse("flush_idle_nopulse", 40);

    mulw = 1'b0;
    mul_signed = MUL_UU;
    multiplicand = 64'd100;
    multiplier = 64'd200;
    mul_valid = 1'b1;
    tick();
    mul_signed = MUL_SS;
    multiplicand = 64'hFFFF_FFFF_FFFF_FFFD;
    multiplier = 64'd7;
    wait_done(c);
    chk("b2b_a_lat", 64'(c), 64'd33);
    chk("b2b_a_hi", result_hi, 64'd0);
    chk("b2b_a_lo", result_lo, 64'd20000);
    chk("b2b_done_ready", 64'(mul_ready), 64'd0);
    tick();
    chk("b2b_idle_ready", 64'(mul_ready), 64'd1);
    tick();
    mul_valid = 1'b0;
    scramble();
    chk("b2b_b_accepted", 64'(mul_ready), 64'd0);
    wait_done(c);
    chk("b2b_b_lat", 64'(c), 64'd33);
    chk("b2b_b_hi", result_hi, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("b2b_b_lo", result_lo, 64'hFFFF_FFFF_FFFF_FFEB);
    tick();

    accept(1'b0, MUL_UU, 64'd11, 64'd13);
    for (int k = 0; k < 19; k++) tick();
    rst = 1'b1;
    tick();
    chk("midrst_ready", 64'(mul_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_hi", result_hi, 64'd0);
    chk("midrst_lo", result_lo, 64'd0);
    chk("midrst_idle_ready", 64'(mul_ready), 64'd1);
    no_pulse("midrst_nopulse", 40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
